// File: rtl/commit_trace_packer.sv
// Commit-trace packer: folds retire, data-memory and trap strobes from the core
// into one aligned commit packet per retired instruction, buffered in a
// show-ahead FIFO and presented to the checker with a valid/ready handshake.
module commit_trace_packer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            retire_valid,
    input  logic [XLEN-1:0] retire_pc,
    input  logic [31:0]     retire_inst,
    input  logic            retire_trap,
    input  logic [31:0]     trap_cause,
    input  logic            mem_valid,
    input  logic [XLEN-1:0] mem_addr,
    input  logic [3:0]      mem_wstrb,
    input  logic [1:0]      mem_ldwidth,
    input  logic [XLEN-1:0] mem_wdata,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            instCommit_valid,
    output logic [31:0]     instCommit_inst,
    output logic [XLEN-1:0] instCommit_pc,
    output logic            mem_read_valid,
    output logic [XLEN-1:0] mem_read_addr,
    output logic [5:0]      mem_read_memWidth,
    output logic [XLEN-1:0] mem_read_data,
    output logic            mem_write_valid,
    output logic [XLEN-1:0] mem_write_addr,
    output logic [5:0]      mem_write_memWidth,
    output logic [XLEN-1:0] mem_write_data,
    output logic            event_valid,
    output logic [31:0]     event_cause,
    output logic [XLEN-1:0] event_exceptionPC,
    output logic [31:0]     event_exceptionInst,
    output logic            overflow,
    output logic            proto_err
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned MW = 6;

    typedef struct packed {
        logic            inst_valid;
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        logic            rd_valid;
        logic [XLEN-1:0] rd_addr;
        logic [MW-1:0]   rd_width;
        logic [XLEN-1:0] rd_data;
        logic            wr_valid;
        logic [XLEN-1:0] wr_addr;
        logic [MW-1:0]   wr_width;
        logic [XLEN-1:0] wr_data;
        logic            ev_valid;
        logic [31:0]     ev_cause;
        logic [XLEN-1:0] ev_pc;
        logic [31:0]     ev_inst;
    } pkt_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] addr;
        logic [3:0]      wstrb;
        logic [1:0]      ldwidth;
        logic [XLEN-1:0] wdata;
        logic            rvalid;
        logic [XLEN-1:0] rdata;
    } pend_t;

    pend_t         pend_q, pend_d;
    pkt_t          pkt_c, head_c;
    pkt_t          mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic          overflow_q, proto_err_q;

    logic            src_valid, src_load, rdata_ok, src_has_data;
    logic [XLEN-1:0] src_addr, src_wdata, src_rdata;
    logic [3:0]      src_wstrb;
    logic [1:0]      src_ldwidth;
    logic [2:0]      strb_cnt;
    logic [MW-1:0]   st_width, ld_width;
    logic            st_err, ld_err, err_c;
    logic            full, pop, do_push, drop;

    // Access source selection (same-cycle bypass), packet formation, protocol checks.
    always_comb begin
        src_valid    = mem_valid | pend_q.valid;
        src_addr     = mem_valid ? mem_addr    : pend_q.addr;
        src_wstrb    = mem_valid ? mem_wstrb   : pend_q.wstrb;
        src_ldwidth  = mem_valid ? mem_ldwidth : pend_q.ldwidth;
        src_wdata    = mem_valid ? mem_wdata   : pend_q.wdata;
        src_load     = src_valid && (src_wstrb == 4'd0);
        rdata_ok     = mem_rvalid && src_load;
        src_has_data = rdata_ok || (!mem_valid && pend_q.rvalid);
        src_rdata    = rdata_ok ? mem_rdata : (mem_valid ? '0 : pend_q.rdata);

        strb_cnt = 3'(src_wstrb[0]) + 3'(src_wstrb[1]) + 3'(src_wstrb[2]) + 3'(src_wstrb[3]);
        st_err   = 1'b0;
        case (strb_cnt)
            3'd1:    st_width = 6'd8;
            3'd2:    st_width = 6'd16;
            3'd4:    st_width = 6'd32;
            default: begin st_width = 6'd32; st_err = 1'b1; end
        endcase
        ld_err = 1'b0;
        case (src_ldwidth)
            2'd0:    ld_width = 6'd8;
            2'd1:    ld_width = 6'd16;
            2'd2:    ld_width = 6'd32;
            default: begin ld_width = 6'd32; ld_err = 1'b1; end
        endcase

        err_c = (mem_valid && pend_q.valid) || (mem_rvalid && !src_load);
        pkt_c = '0;
        if (retire_valid) begin
            pkt_c.inst = retire_inst;
            pkt_c.pc   = retire_pc;
            if (retire_trap) begin
                pkt_c.ev_valid = 1'b1;
                pkt_c.ev_cause = trap_cause;
                pkt_c.ev_pc    = retire_pc;
                pkt_c.ev_inst  = retire_inst;
            end else begin
                pkt_c.inst_valid = 1'b1;
                if (src_valid && !src_load) begin
                    pkt_c.wr_valid = 1'b1;
                    pkt_c.wr_addr  = src_addr;
                    pkt_c.wr_width = st_width;
                    pkt_c.wr_data  = src_wdata;
                    err_c          = err_c | st_err;
                end else if (src_load) begin
                    pkt_c.rd_valid = 1'b1;
                    pkt_c.rd_addr  = src_addr;
                    pkt_c.rd_width = ld_width;
                    pkt_c.rd_data  = src_has_data ? src_rdata : '0;
                    err_c          = err_c | ld_err | !src_has_data;
                end
            end
        end

        pend_d = pend_q;
        if (retire_valid) begin
            pend_d = '0;
        end else if (mem_valid) begin
            pend_d.valid   = 1'b1;
            pend_d.addr    = mem_addr;
            pend_d.wstrb   = mem_wstrb;
            pend_d.ldwidth = mem_ldwidth;
            pend_d.wdata   = mem_wdata;
            pend_d.rvalid  = rdata_ok;
            pend_d.rdata   = rdata_ok ? mem_rdata : '0;
        end else if (rdata_ok) begin
            pend_d.rvalid = 1'b1;
            pend_d.rdata  = mem_rdata;
        end
    end

    assign out_valid = (wr_ptr_q != rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop       = out_valid && out_ready;
    assign do_push   = retire_valid && (!full || pop);
    assign drop      = retire_valid && full && !pop;

    // Pending access, FIFO pointers and sticky error flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            overflow_q  <= overflow_q | drop;
            proto_err_q <= proto_err_q | err_c;
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // Packet storage; contents are only observed through valid pointers.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= pkt_c;
    end

    // Head packet, zeroed when the FIFO is empty so every field gates on out_valid.
    always_comb begin
        head_c = out_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
    end

    assign instCommit_valid    = head_c.inst_valid;
    assign instCommit_inst     = head_c.inst;
    assign instCommit_pc       = head_c.pc;
    assign mem_read_valid      = head_c.rd_valid;
    assign mem_read_addr       = head_c.rd_addr;
    assign mem_read_memWidth   = head_c.rd_width;
    assign mem_read_data       = head_c.rd_data;
    assign mem_write_valid     = head_c.wr_valid;
    assign mem_write_addr      = head_c.wr_addr;
    assign mem_write_memWidth  = head_c.wr_width;
    assign mem_write_data      = head_c.wr_data;
    assign event_valid         = head_c.ev_valid;
    assign event_cause         = head_c.ev_cause;
    assign event_exceptionPC   = head_c.ev_pc;
    assign event_exceptionInst = head_c.ev_inst;
    assign overflow            = overflow_q;
    assign proto_err           = proto_err_q;

endmodule

// File: doc/commit_trace_packer.md
Name: commit_trace_packer

Overview:
Core-side producer for the commit-trace checker interface. It takes the raw retire, data-memory and trap strobes from the nerv core. For each retired instruction it builds one aligned commit packet: instruction, PC, memory read/write record and trap event. Packets are buffered in a small show-ahead FIFO and presented to the checker with a valid/ready handshake.

Parameters:
DEPTH, 4, packet FIFO entries (power of two, >=2)
XLEN, 32, data/address width

Ports:
clock  in  1  single clock, rising edge
reset_n  in  1  asynchronous active-low reset
retire_valid  in  1  instruction retires this cycle
retire_pc  in  XLEN  PC of retiring instruction
retire_inst  in  32  encoding of retiring instruction
retire_trap  in  1  retiring instruction trapped (qualified by retire_valid)
trap_cause  in  32  mcause value for trap
mem_valid  in  1  data access issued this cycle
mem_addr  in  XLEN  access byte address
mem_wstrb  in  4  byte write mask; 0 = load
mem_ldwidth  in  2  load size: 0 byte, 1 half, 2 word
mem_wdata  in  XLEN  store data
mem_rvalid  in  1  load data returned this cycle
mem_rdata  in  XLEN  load data
out_valid  out  1  head packet valid
out_ready  in  1  checker accepts head packet
instCommit_valid, instCommit_inst, instCommit_pc  out  1/32/XLEN  commit record
mem_read_valid, mem_read_addr, mem_read_memWidth, mem_read_data  out  1/XLEN/6/XLEN  load record
mem_write_valid, mem_write_addr, mem_write_memWidth, mem_write_data  out  1/XLEN/6/XLEN  store record
event_valid, event_cause, event_exceptionPC, event_exceptionInst  out  1/32/XLEN/32  trap record
overflow  out  1  sticky: packet dropped on full FIFO
proto_err  out  1  sticky: protocol violation seen

Behaviour:
- Reset (async, reset_n=0): FIFO empty; pending-access register clear; overflow=0; proto_err=0; all outputs 0.
- Pending access register: loaded on mem_valid with addr, wstrb, ldwidth, wdata. Load data slot filled on mem_rvalid (same or later cycle).
- A second mem_valid while an access is pending and unretired sets proto_err. The new access overwrites the pending one.
- mem_rvalid with no pending load sets proto_err; the data is ignored.
- Packet formation, on cycle N where retire_valid=1:
  - Access source: the pending access, or the current mem_valid access if it occurs in the same cycle (bypass).
  - Store (wstrb!=0): mem_write_valid=1. memWidth = 8×popcount(wstrb), legal values 8/16/32. Any other popcount sets proto_err and records width 32.
  - Load: mem_read_valid=1. memWidth = 8<<ldwidth; ldwidth=3 sets proto_err and records 32. read_data = captured rdata, or bypassed mem_rdata if mem_rvalid in cycle N.
  - Load retiring with no data yet: proto_err set, read_data=0.
  - Pending register cleared in cycle N.
  - retire_trap=1: instCommit_valid=0; event_valid=1, cause=trap_cause, exceptionPC=retire_pc, exceptionInst=retire_inst; mem records forced invalid.
  - Otherwise instCommit_valid=1, event_valid=0.
- FIFO:
  - Push on packet formation; pop on out_valid&&out_ready.
  - Latency: retire at N with FIFO empty -> out_valid=1 at N+1.
  - Full with push and no pop: packet dropped, overflow set (sticky until reset).
  - Full with push and pop in the same cycle: both happen, no drop.
  - Empty: out_valid=0, and the push is not visible until N+1 (no combinational bypass).
  - Pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH.
- Outputs:
  - All *_valid outputs are ANDed with out_valid. Data fields show the head entry when out_valid=1 and 0 otherwise.
  - The head packet holds stable while out_valid && !out_ready.
- reset_n asserted mid-operation: pending access and buffered packets discarded immediately. No packet is emitted after release until a new retire.

Test Plan:
- Store: mem_valid addr=0x100 wstrb=0xF wdata=0xDEADBEEF, retire pc=0x80 inst=0x00A12023 same cycle, out_ready=1 -> next cycle out_valid=1, instCommit_valid=1, mem_write_valid=1, addr 0x100, memWidth=32, data 0xDEADBEEF.
- Load: mem_valid addr=0x204 wstrb=0 ldwidth=1 at N, mem_rvalid rdata=0x1234 at N+1, retire at N+2 -> packet read_valid=1, memWidth=16, read_data=0x1234, write_valid=0.
- Trap: retire_trap=1, cause=2, pc=0x40, inst=0xFFFFFFFF -> event_valid=1, cause 2, exceptionPC 0x40, exceptionInst 0xFFFFFFFF, instCommit_valid=0.
- Backpressure: out_ready=0, 5 consecutive retires with DEPTH=4 -> 4 packets held in order, overflow=1. Then out_ready=1 -> packets drain in retire order.
- Full FIFO, push and pop in the same cycle -> no drop, overflow stays 0, occupancy unchanged.
- Protocol errors: two mem_valid before a retire -> proto_err=1, packet carries the second address. Separately, reset_n pulsed low with 2 packets queued -> out_valid=0 at once, and overflow/proto_err cleared.
